// File: rtl/cake_pkg.sv
// Shared constants for the cake order round controller: cake type range,
// slot packing widths and the round FSM state encodings.
package cake_pkg;

    localparam int SLOT_W = 3;
    localparam int VEC_W  = 18;

    localparam logic [2:0] CAKE_NONE = 3'd0;
    localparam logic [2:0] CAKE_MIN  = 3'd1;
    localparam logic [2:0] CAKE_MAX  = 3'd6;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GEN     = 3'd1;
    localparam logic [2:0] ST_COLLECT = 3'd2;
    localparam logic [2:0] ST_SCORE   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // A caught cake counts only if it is a real cake type (0 and 7 are junk codes)
    function automatic logic is_cake_type(input logic [2:0] t);
        return (t != CAKE_NONE) && (t >= CAKE_MIN) && (t <= CAKE_MAX);
    endfunction

endpackage

// File: rtl/cake_lfsr.sv
// Free-running 16-bit Galois LFSR that supplies a cake type 1..6 every cycle.
module cake_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [2:0] type_out
);

    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_next;
    logic [2:0]  w_mod6;

    // Right-shifting Galois step; feedback taps folded in when the bit shifted out is 1
    always_comb begin
        w_lfsr_next = r_lfsr >> 1;
        if (r_lfsr[0]) begin
            w_lfsr_next = (r_lfsr >> 1) ^ 16'hB400;
        end
    end

    // LFSR state, restarted from the seed on reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // Fold the low three bits into 0..5 (6 and 7 wrap to 0 and 1), then shift to 1..6
    always_comb begin
        w_mod6 = r_lfsr[2:0];
        if (r_lfsr[2:0] >= 3'd6) begin
            w_mod6 = r_lfsr[2:0] - 3'd6;
        end
        type_out = w_mod6 + 3'd1;
    end

endmodule

// File: rtl/order_tray.sv
// Round controller: draws a 5-cake recipe, packs caught cakes into a slot
// vector and holds a scoring request until the score screen acknowledges.
module order_tray
    import cake_pkg::*;
#(
    parameter int          NUM_SLOTS = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        catch_valid,
    input  logic [2:0]  catch_type,
    input  logic        done_score,
    output logic [17:0] recipe,
    output logic [17:0] caught_cake,
    output logic [2:0]  slots_filled,
    output logic        ld_score,
    output logic        round_busy,
    output logic        round_done
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_SLOTS - 1);

    logic [2:0]       r_state;
    logic [2:0]       r_gen_idx;
    logic [VEC_W-1:0] r_recipe;
    logic [VEC_W-1:0] r_caught;
    logic [2:0]       r_filled;
    logic             r_ld_score;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_state_nxt;
    logic [2:0]       w_draw;
    logic             w_accept;

    cake_lfsr #(
        .SEED     (LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .resetn   (resetn),
        .type_out (w_draw)
    );

    assign w_accept = (r_state == ST_COLLECT) && catch_valid && is_cake_type(catch_type);

    // Next-state decision for the round FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_nxt = ST_GEN;
            ST_GEN:     if (r_gen_idx == LAST_IDX) w_state_nxt = ST_COLLECT;
            ST_COLLECT: if (w_accept && (r_filled == LAST_IDX)) w_state_nxt = ST_SCORE;
            ST_SCORE:   if (done_score) w_state_nxt = ST_DONE;
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // State and status flags; flags follow the next state so they line up with it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_ld_score <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ld_score <= (w_state_nxt == ST_SCORE);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= (w_state_nxt == ST_DONE);
        end
    end

    // Recipe generation and caught-cake packing; vectors persist until the next start
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_gen_idx <= '0;
            r_recipe  <= '0;
            r_caught  <= '0;
            r_filled  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_gen_idx <= '0;
                        r_recipe  <= '0;
                        r_caught  <= '0;
                        r_filled  <= '0;
                    end
                end
                ST_GEN: begin
                    r_recipe[r_gen_idx*SLOT_W +: SLOT_W] <= w_draw;
                    r_gen_idx <= r_gen_idx + 3'd1;
                end
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_caught[r_filled*SLOT_W +: SLOT_W] <= catch_type;
                        r_filled <= r_filled + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign recipe       = r_recipe;
    assign caught_cake  = r_caught;
    assign slots_filled = r_filled;
    assign ld_score     = r_ld_score;
    assign round_busy   = r_busy;
    assign round_done   = r_done;

endmodule

// File: tb/tb_order_tray.sv
// Scoreboard bench for order_tray: catches push expected vectors, which are
// popped and compared once the DUT has clocked them in.
`timescale 1ns/1ps
module tb_order_tray;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        catch_valid = 1'b0;
    logic [2:0]  catch_type = 3'd0;
    logic        done_score = 1'b0;
    logic [17:0] recipe;
    logic [17:0] caught_cake;
    logic [2:0]  slots_filled;
    logic        ld_score;
    logic        round_busy;
    logic        round_done;

    order_tray dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .catch_valid  (catch_valid),
        .catch_type   (catch_type),
        .done_score   (done_score),
        .recipe       (recipe),
        .caught_cake  (caught_cake),
        .slots_filled (slots_filled),
        .ld_score     (ld_score),
        .round_busy   (round_busy),
        .round_done   (round_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [17:0] cake;
        logic [2:0]  filled;
        logic        ld;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // reference model state
    logic [15:0] m_lfsr;
    logic [17:0] m_cake;
    logic [17:0] m_rec;
    int          m_filled;
    bit          m_collect;
    logic        m_ld;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) m_lfsr <= 16'hACE1;
        else if (m_lfsr[0]) m_lfsr <= {1'b0, m_lfsr[15:1]} ^ 16'hB400;
        else m_lfsr <= {1'b0, m_lfsr[15:1]};
    end

    function automatic logic [2:0] model_type(input logic [15:0] l);
        int v;
        v = (int'(l[2:0]) % 6) + 1;
        return 3'(v);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_clear();
        m_cake    = '0;
        m_filled  = 0;
        m_collect = 1'b0;
        m_ld      = 1'b0;
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val({tag, "_cake"}, caught_cake, e.cake);
            check_val({tag, "_fill"}, slots_filled, e.filled);
            check_val({tag, "_ld"}, ld_score, e.ld);
            check_val({tag, "_rec"}, recipe, m_rec);
        end
    endtask

    task automatic start_round(input bit catch_at_start, input bit catch_in_gen);
        logic [17:0] exp_rec;
        start = 1'b1;
        if (catch_at_start) begin
            catch_valid = 1'b1;
            catch_type  = 3'd2;
        end
        tick();
        start       = 1'b0;
        catch_valid = 1'b0;
        check_val("start_busy", round_busy, 1);
        check_val("start_clr_cake", caught_cake, 0);
        check_val("start_clr_fill", slots_filled, 0);
        check_val("start_clr_rec", recipe, 0);
        exp_rec = '0;
        for (int k = 0; k < 5; k++) begin
            exp_rec[3*k +: 3] = model_type(m_lfsr);
            if (catch_in_gen && k == 2) begin
                catch_valid = 1'b1;
                catch_type  = 3'd4;
            end
            tick();
            catch_valid = 1'b0;
        end
        check_val("gen_recipe", recipe, exp_rec);
        check_val("gen_rec_top", recipe[17:15], 0);
        for (int k = 0; k < 5; k++) begin
            logic [2:0] s;
            s = recipe[3*k +: 3];
            check_val("gen_slot_range", (s >= 3'd1 && s <= 3'd6), 1);
        end
        check_val("gen_ignore_cake", caught_cake, 0);
        check_val("gen_ignore_fill", slots_filled, 0);
        m_rec = exp_rec;
        model_clear();
        m_collect = 1'b1;
    endtask

    task automatic do_catch(input logic [2:0] t);
        exp_t e;
        catch_valid = 1'b1;
        catch_type  = t;
        if (m_collect && t >= 3'd1 && t <= 3'd6) begin
            m_cake[3*m_filled +: 3] = t;
            m_filled++;
            if (m_filled == 5) begin
                m_collect = 1'b0;
                m_ld      = 1'b1;
            end
        end
        e.cake = m_cake; e.filled = 3'(m_filled); e.ld = m_ld;
        sb_q.push_back(e);
        tick();
        catch_valid = 1'b0;
        pop_compare("catch");
    endtask

    // a cycle carrying only start/done_score that must be ignored
    task automatic stray_cycle(input bit s, input bit d);
        exp_t e;
        start      = s;
        done_score = d;
        e.cake = m_cake; e.filled = 3'(m_filled); e.ld = m_ld;
        sb_q.push_back(e);
        tick();
        start      = 1'b0;
        done_score = 1'b0;
        pop_compare("stray");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stable;
        int seen;
        int lat;
        model_clear();
        m_rec = '0;
        #12;
        check_val("rst_recipe", recipe, 0);
        check_val("rst_cake", caught_cake, 0);
        check_val("rst_flags", {slots_filled, ld_score, round_busy, round_done}, 0);
        check_val("rst_lfsr", dut.u_lfsr.r_lfsr, 16'hACE1);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // round A: packing, invalid codes, catches in GEN and SCORE
        start_round(1'b0, 1'b1);
        do_catch(3'd0);
        do_catch(3'd1);
        do_catch(3'd7);
        stray_cycle(1'b1, 1'b1);
        do_catch(3'd2);
        do_catch(3'd3);
        do_catch(3'd4);
        do_catch(3'd5);
        check_val("pack_058D1", caught_cake, 18'h058D1);
        check_val("pack_busy", round_busy, 1);
        do_catch(3'd6);
        stray_cycle(1'b1, 1'b0);

        // scoring handshake held off for 200 cycles
        stable = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (ld_score === 1'b1 && round_done === 1'b0 && caught_cake === 18'h058D1 &&
                recipe === m_rec && slots_filled === 3'd5)
                stable++;
        end
        check_val("score_hold", stable, 200);
        done_score = 1'b1;
        tick();
        done_score = 1'b0;
        check_val("done_pulse", round_done, 1);
        check_val("done_ld_drop", ld_score, 0);
        check_val("done_busy", round_busy, 1);
        tick();
        check_val("done_pulse_end", round_done, 0);
        check_val("idle_busy", round_busy, 0);
        check_val("idle_keep_cake", caught_cake, 18'h058D1);
        check_val("idle_keep_rec", recipe, m_rec);
        m_ld = 1'b0;
        stray_cycle(1'b0, 1'b1);
        check_val("idle_done_ign", {round_done, round_busy}, 0);

        // round B: start with simultaneous catch, different pattern
        start_round(1'b1, 1'b0);
        do_catch(3'd6);
        do_catch(3'd6);
        do_catch(3'd1);
        do_catch(3'd3);
        do_catch(3'd2);
        check_val("packB", caught_cake, {3'd0, 3'd2, 3'd3, 3'd1, 3'd6, 3'd6});
        done_score = 1'b1;
        seen = 0;
        lat = 0;
        for (int i = 1; i <= 8 && seen == 0; i++) begin
            tick();
            done_score = 1'b0;
            if (round_done === 1'b1) begin
                seen = 1;
                lat  = i;
            end
        end
        done_score = 1'b0;
        check_val("B_done_seen", seen, 1);
        check_val("B_done_lat", lat, 1);
        tick();
        check_val("B_idle", round_busy, 0);

        // round C: reset asserted in the middle of COLLECT
        start_round(1'b0, 1'b0);
        do_catch(3'd4);
        do_catch(3'd5);
        #2;
        resetn = 1'b0;
        #1;
        check_val("arst_recipe", recipe, 0);
        check_val("arst_cake", caught_cake, 0);
        check_val("arst_flags", {slots_filled, ld_score, round_busy, round_done}, 0);
        check_val("arst_state", dut.r_state, 0);
        check_val("arst_lfsr", dut.u_lfsr.r_lfsr, 16'hACE1);
        tick();
        tick();
        resetn = 1'b1;
        model_clear();
        m_rec = '0;
        tick();

        // round D: full round after reset
        start_round(1'b0, 1'b0);
        do_catch(3'd5);
        do_catch(3'd4);
        do_catch(3'd3);
        do_catch(3'd2);
        do_catch(3'd1);
        check_val("packD", caught_cake, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
